mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates the single-port 16-bit unified memory between the instruction-fetch port (I) and the load/store port (D).
- Sits between the fetch/execute stages and the memory, and drives the memory's enable, wr, addr and data_in.
- Each request runs through a fixed 3-state sequence and returns a one-cycle ack with registered read data.
- D has priority. A starvation counter guarantees I eventually wins.

Parameters:
- ADDR_WIDTH, 16, byte-address width; must match the memory's ADDR_WIDTH.
- STARVE_LIMIT, 4, number of consecutive lost I arbitrations after which I wins over D (1..15).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_req  in  1  fetch request; held high until i_ack
- i_addr  in  ADDR_WIDTH  fetch byte address; stable while i_req
- i_ack  out  1  one-cycle pulse; fetch complete
- i_rdata  out  16  fetched word; valid with i_ack
- d_req  in  1  data request; held high until d_ack
- d_wr  in  1  1=store, 0=load; stable while d_req
- d_addr  in  ADDR_WIDTH  data byte address; stable while d_req
- d_wdata  in  16  store data; stable while d_req
- d_ack  out  1  one-cycle pulse; data access complete
- d_rdata  out  16  load data; valid with d_ack; 0 for stores
- mem_enable  out  1  to memory enable
- mem_wr  out  1  to memory wr
- mem_addr  out  ADDR_WIDTH  to memory addr
- mem_data_in  out  16  to memory data_in
- mem_data_out  in  16  from memory (combinational read)
- busy  out  1  high when the state is not IDLE

Behaviour:
- Reset: the single clock is clk. Reset rst is synchronous and active-high.
  - On a rst-high edge: state<=IDLE; i_ack, d_ack <= 0; i_rdata, d_rdata <= 0; starve_cnt <= 0; latched request registers <= 0.
  - While rst is high, mem_enable and mem_wr are forced to 0 combinationally, so preload during reset is not disturbed.
- State machine: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - Sample i_req and d_req.
  - If neither is high, stay in IDLE.
  - Otherwise choose the winner:
    - D wins if d_req and not (i_req and starve_cnt >= STARVE_LIMIT).
    - Otherwise I wins.
  - Latch the winner's id, addr, wr (I always 0) and wdata (I: 0). Go to ACCESS.
- ACCESS:
  - Drive from the latched registers only: mem_enable=1, mem_wr=latched wr, mem_addr=latched addr, mem_data_in=latched wdata.
  - The memory write commits at the end of this cycle.
  - At the end of the cycle, capture mem_data_out into the winner's rdata register. A store captures 0.
  - Go to RESP.
- RESP:
  - Assert the winner's ack for exactly this cycle. The other ack stays 0.
  - rdata holds its value until that port's next ack.
  - Go to IDLE. Requests are not sampled in RESP.
- Outside ACCESS: mem_enable=0, mem_wr=0. mem_addr and mem_data_in hold their latched values.
- Latency: request seen in IDLE at cycle N gives ack in cycle N+2. An uncontended back-to-back stream from one port completes one access per 3 cycles.
- Requester rule: after seeing ack, drop req or present a new request in the following cycle. An unchanged held req is treated as a new request.
- starve_cnt (4-bit, saturating at 15), evaluated in IDLE only:
  - Increments when i_req=1 and D wins.
  - Clears when I wins or when i_req=0.
  - Unchanged in ACCESS and RESP.
- Simultaneous i_req and d_req with starve_cnt < STARVE_LIMIT: D served. I stays pending; the next IDLE re-arbitrates.
- Address bit 0 is passed through unchanged; the memory ignores it. No alignment checking.
- Input changes during ACCESS or RESP have no effect, because the memory is driven only from latched registers.
- Reset mid-operation (rst in ACCESS or RESP):
  - In-flight access is dropped; no ack is issued.
  - A store in ACCESS on a rst-high edge is not committed: the memory ignores writes under rst, and mem_wr is forced 0.

Test Plan:
- Reset: hold rst 2 cycles with i_req=d_req=1 -> mem_enable=0 throughout. All acks and rdata are 0; busy=0 on the first post-reset cycle.
- I alone: i_req=1, i_addr=0x0010, memory word[8]=0xBEEF -> mem_enable=1 with mem_addr=0x0010 in cycle N+1. i_ack=1 and i_rdata=0xBEEF in N+2; busy high N+1..N+2.
- D store then load:
  - Store d_wr=1, d_addr=0x0020, d_wdata=0x1234 -> d_ack at N+2, d_rdata=0.
  - Then load d_wr=0, d_addr=0x0021 -> d_rdata=0x1234 (bit 0 ignored).
- Contention: i_req and d_req both high in the same IDLE cycle -> d_ack first (N+2). i_ack at N+5 after d_req drops.
- Starvation: D requests continuously, I held, STARVE_LIMIT=4 -> I wins on the 5th arbitration, after 4 D services. starve_cnt returns to 0 afterwards.
- Reset mid-access: rst high in the ACCESS cycle of a store to 0x0030 with data 0xAAAA -> no d_ack. Word at 0x0030 is unchanged on a later load.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbiter for the shared single-port 16-bit memory. It serves the fetch (I) and
// load/store (D) ports through IDLE -> ACCESS -> RESP, with D having priority.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ack,
  output logic [15:0]           i_rdata,
  input  logic                  d_req,
  input  logic                  d_wr,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [15:0]           d_wdata,
  output logic                  d_ack,
  output logic [15:0]           d_rdata,
  output logic                  mem_enable,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_data_in,
  input  logic [15:0]           mem_data_out,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic                  is_d;
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [15:0]           wdata;
  } req_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state, state_nxt;
  req_t       lat, lat_nxt;
  logic [3:0] starve_cnt, starve_nxt;
  logic       d_win;

  always_comb begin
    state_nxt  = state;
    lat_nxt    = lat;
    starve_nxt = starve_cnt;
    d_win      = d_req && !(i_req && (starve_cnt >= LIMIT));
    unique case (state)
      IDLE: begin
        // Counter only tracks consecutive I losses; any I win or absent I clears it.
        if (i_req && d_win)
          starve_nxt = (starve_cnt == 4'hF) ? 4'hF : starve_cnt + 4'd1;
        else
          starve_nxt = 4'd0;
        if (i_req || d_req) begin
          state_nxt = ACCESS;
          if (d_win) begin
            lat_nxt.is_d  = 1'b1;
            lat_nxt.wr    = d_wr;
            lat_nxt.addr  = d_addr;
            lat_nxt.wdata = d_wdata;
          end else begin
            lat_nxt.is_d  = 1'b0;
            lat_nxt.wr    = 1'b0;
            lat_nxt.addr  = i_addr;
            lat_nxt.wdata = 16'h0;
          end
        end
      end
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lat        <= '0;
      starve_cnt <= 4'd0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      i_rdata    <= 16'h0;
      d_rdata    <= 16'h0;
    end else begin
      state      <= state_nxt;
      lat        <= lat_nxt;
      starve_cnt <= starve_nxt;
      i_ack      <= (state == ACCESS) && !lat.is_d;
      d_ack      <= (state == ACCESS) && lat.is_d;
      if (state == ACCESS) begin
        if (lat.is_d) d_rdata <= lat.wr ? 16'h0 : mem_data_out;
        else          i_rdata <= mem_data_out;
      end
    end
  end

  // Memory strobes are gated by rst so preload or a dropped store is never disturbed.
  assign mem_enable  = (state == ACCESS) && !rst;
  assign mem_wr      = mem_enable && lat.wr;
  assign mem_addr    = lat.addr;
  assign mem_data_in = lat.wdata;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter. A transaction-level model predicts
// grant order, ack timing, memory strobes and read data cycle by cycle.
module tb_mem_arbiter;
  localparam int AW    = 16;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, d_req, d_wr;
  logic [AW-1:0] i_addr, d_addr;
  logic [15:0]   d_wdata;
  logic          i_ack, d_ack, mem_enable, mem_wr, busy;
  logic [15:0]   i_rdata, d_rdata, mem_data_in, mem_data_out;
  logic [AW-1:0] mem_addr;

  mem_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pat(int k);
    return (k == 8) ? 16'hBEEF : (16'(k * 257) ^ 16'h5A5A);
  endfunction

  // Word-addressed memory; bit 0 of the byte address is ignored.
  logic [15:0] mem [0:127];
  logic        preload;
  assign mem_data_out = mem[mem_addr[7:1]];
  always @(posedge clk) begin
    if (rst && preload) begin
      for (int k = 0; k < 128; k++) mem[k] <= pat(k);
    end else if (mem_enable && mem_wr && !rst) begin
      mem[mem_addr[7:1]] <= mem_data_in;
    end
  end

  int errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: a grant taken in a free cycle occupies the memory the next
  // cycle and acks the cycle after; the arbiter is free again three cycles on.
  logic [15:0]   ref_mem [0:127];
  int            m_ph = 0;
  logic          m_known = 1'b0;
  int            m_losses = 0;
  logic          m_is_d = 1'b0, m_wr = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [15:0]   m_wdata = '0, m_i_rdata = '0, m_d_rdata = '0;
  logic          m_i_done = 1'b0, m_d_done = 1'b0;
  logic          s_i_ack, s_d_ack;

  task automatic model_step();
    logic        i_win;
    logic [15:0] data;
    m_i_done = 1'b0;
    m_d_done = 1'b0;
    if (rst) begin
      m_known = 1'b1; m_ph = 0; m_losses = 0;
      m_is_d = 1'b0; m_wr = 1'b0; m_addr = '0; m_wdata = '0;
      m_i_rdata = '0; m_d_rdata = '0;
    end else begin
      case (m_ph)
        0: begin
          if (i_req || d_req) begin
            i_win = i_req && (!d_req || m_losses >= LIMIT);
            if (i_req && !i_win) m_losses = (m_losses < 15) ? m_losses + 1 : 15;
            else                 m_losses = 0;
            m_is_d  = !i_win;
            m_wr    = i_win ? 1'b0 : d_wr;
            m_addr  = i_win ? i_addr : d_addr;
            m_wdata = i_win ? 16'h0 : d_wdata;
            m_ph    = 1;
          end else begin
            m_losses = 0;
          end
        end
        1: begin
          data = m_wr ? 16'h0 : ref_mem[m_addr[7:1]];
          if (m_wr) ref_mem[m_addr[7:1]] = m_wdata;
          if (m_is_d) m_d_rdata = data;
          else        m_i_rdata = data;
          m_ph = 2;
        end
        default: begin
          if (m_is_d) m_d_done = 1'b1;
          else        m_i_done = 1'b1;
          m_ph = 0;
        end
      endcase
    end
  endtask

  task automatic tick();
    @(negedge clk);
    s_i_ack = i_ack;
    s_d_ack = d_ack;
    chk("mem_enable", mem_enable, (m_ph == 1) && !rst);
    chk("mem_wr", mem_wr, (m_ph == 1) && !rst && m_wr);
    if (m_known) begin
      chk("busy", busy, m_ph != 0);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_data_in", mem_data_in, m_wdata);
      chk("i_ack", i_ack, (m_ph == 2) && !m_is_d);
      chk("d_ack", d_ack, (m_ph == 2) && m_is_d);
      chk("i_rdata", i_rdata, m_i_rdata);
      chk("d_rdata", d_rdata, m_d_rdata);
    end
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    int   nd;
    logic got;
    for (int k = 0; k < 128; k++) ref_mem[k] = pat(k);
    preload = 1'b1;
    rst = 1'b1;
    i_req = 1'b1; i_addr = 16'h0010;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0020; d_wdata = 16'h0;

    // Reset held with both requests up
    tick(); tick();
    preload = 1'b0;

    // I alone
    rst = 1'b0; d_req = 1'b0;
    tick(); tick(); tick();
    i_req = 1'b0;
    chk("i_alone_rdata", i_rdata, 16'hBEEF);

    // D store then load with bit 0 set
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0020; d_wdata = 16'h1234;
    tick(); tick(); tick();
    chk("store_rdata", d_rdata, 16'h0);
    d_wr = 1'b0; d_addr = 16'h0021; d_wdata = 16'h0;
    tick(); tick(); tick();
    d_req = 1'b0;
    chk("load_rdata", d_rdata, 16'h1234);
    tick();

    // Contention in the same free cycle
    i_req = 1'b1; i_addr = 16'h0010;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0020;
    tick(); tick(); tick();
    chk("cont_d_first", {s_d_ack, s_i_ack}, 2'b10);
    d_req = 1'b0;
    tick(); tick(); tick();
    chk("cont_i_n5", {s_d_ack, s_i_ack}, 2'b01);
    i_req = 1'b0;
    tick();

    // Starvation: D continuous, I held for two rounds
    i_req = 1'b1; d_req = 1'b1;
    for (int r = 0; r < 2; r++) begin
      nd = 0; got = 1'b0;
      for (int k = 0; k < 60 && !got; k++) begin
        tick();
        if (s_d_ack) nd++;
        if (s_i_ack) got = 1'b1;
      end
      chk("starve_i_won", got, 1'b1);
      chk("starve_d_count", nd, LIMIT);
    end
    i_req = 1'b0; d_req = 1'b0;
    tick();

    // Reset during the ACCESS cycle of a store
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0030; d_wdata = 16'hAAAA;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; d_req = 1'b0;
    tick();
    d_req = 1'b1; d_wr = 1'b0; d_wdata = 16'h0;
    tick(); tick(); tick();
    d_req = 1'b0;
    chk("rst_store_dropped", d_rdata, pat(24));
    tick();

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      if (i_req && m_i_done) begin
        if ($urandom_range(0, 3) != 0) i_addr = 16'($urandom);
        else                           i_req = 1'b0;
      end else if (!i_req && $urandom_range(0, 2) == 0) begin
        i_req = 1'b1; i_addr = 16'($urandom);
      end
      if (d_req && m_d_done) begin
        if ($urandom_range(0, 3) != 0) begin
          d_wr = 1'($urandom_range(0, 1)); d_addr = 16'($urandom); d_wdata = 16'($urandom);
        end else begin
          d_req = 1'b0;
        end
      end else if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1; d_wr = 1'($urandom_range(0, 1));
        d_addr = 16'($urandom); d_wdata = 16'($urandom);
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
